// File: rtl/tap_accumulator_pkg.sv
// Shared FIR definitions: tap-accumulator FSM states, tap count and selector width.
package tap_accumulator_pkg;

  // Number of taps summed per result, and the matching 8:1 selector width.
  localparam int NUM_TAPS  = 8;
  localparam int SEL_WIDTH = 3;

  // Select value of the final tap; reaching it closes the current sum.
  localparam logic [SEL_WIDTH-1:0] LAST_TAP = SEL_WIDTH'(NUM_TAPS - 1);

  // Accumulator FSM: wait for start, walk the taps, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } tap_state_e;

endpackage : tap_accumulator_pkg

// File: rtl/tap_accumulator.sv
// Tap accumulator: walks an external 8:1 product selector through taps 0..7,
// sums the signed products and presents the registered result with a
// valid/ready handshake. A new sum can start in the handshake cycle.
module tap_accumulator
  import tap_accumulator_pkg::*;
#(
  parameter int OUT_DATA_WIDTH = 21,
  parameter int ACC_WIDTH      = OUT_DATA_WIDTH + 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic [SEL_WIDTH-1:0]      select_lines,
  input  logic [OUT_DATA_WIDTH-1:0] mux_out,
  output logic [ACC_WIDTH-1:0]      sum_out,
  output logic                      sum_valid,
  input  logic                      sum_ready
);

  localparam int EXT_WIDTH = ACC_WIDTH - OUT_DATA_WIDTH;

  tap_state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]      sel_q, sel_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [ACC_WIDTH-1:0]      sum_q, sum_d;
  logic                      valid_q, valid_d;

  logic [ACC_WIDTH-1:0]      product_ext;
  logic [ACC_WIDTH-1:0]      acc_plus_product;
  logic                      handshake;

  // Sign-extend the selected product to accumulator width and add it.
  assign product_ext      = {{EXT_WIDTH{mux_out[OUT_DATA_WIDTH-1]}}, mux_out};
  assign acc_plus_product = acc_q + product_ext;
  assign handshake        = valid_q && sum_ready;

  // State and datapath registers; reset discards any partial or pending sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath decisions for the IDLE/ACCUM/HOLD sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          acc_d   = '0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        // start is ignored here; the tap walk always runs to completion.
        if (sel_q == LAST_TAP) begin
          sum_d   = acc_plus_product;
          valid_d = 1'b1;
          acc_d   = acc_plus_product;
          sel_d   = '0;
          state_d = HOLD;
        end else begin
          acc_d = acc_plus_product;
          sel_d = sel_q + SEL_WIDTH'(1);
        end
      end

      HOLD: begin
        // sum_out is left untouched so it keeps its value after the handshake.
        if (handshake) begin
          valid_d = 1'b0;
          if (start) begin
            acc_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers; select has no path from any input.
  assign busy         = (state_q != IDLE);
  assign select_lines = sel_q;
  assign sum_out      = sum_q;
  assign sum_valid    = valid_q;

endmodule : tap_accumulator

// File: tb/tb_tap_accumulator.sv
// Directed-plus-random bench for tap_accumulator with a behavioural 8:1
// selector and an arithmetic reference sum.
module tb_tap_accumulator;

  localparam int OW = 21;
  localparam int AW = OW + 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic [2:0]    select_lines;
  logic [OW-1:0] mux_out;
  logic [AW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;

  logic [OW-1:0] prod [8];

  int checks = 0;
  int errors = 0;

  tap_accumulator #(.OUT_DATA_WIDTH(OW), .ACC_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .select_lines (select_lines),
    .mux_out      (mux_out),
    .sum_out      (sum_out),
    .sum_valid    (sum_valid),
    .sum_ready    (sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sibling 8:1 selector model.
  always_comb mux_out = prod[select_lines];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] model_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'($signed(prod[i]));
    return AW'(s);
  endfunction

  task automatic load_random();
    for (int i = 0; i < 8; i++) prod[i] = OW'($urandom);
  endtask

  task automatic load_const(input logic [OW-1:0] v);
    for (int i = 0; i < 8; i++) prod[i] = v;
  endtask

  // Caller sets start=1 before calling. Checks the full 8-edge walk and the result.
  task automatic run_sum(input logic [AW-1:0] exp, input bit keep_start, input string name);
    tick();
    if (!keep_start) start = 1'b0;
    check({name, " start busy"}, 32'(busy), 32'd1);
    check({name, " start sel"}, 32'(select_lines), 32'd0);
    check({name, " start valid"}, 32'(sum_valid), 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check({name, " walk sel"}, 32'(select_lines), 32'(k));
      check({name, " walk valid"}, 32'(sum_valid), 32'd0);
    end
    tick();
    check({name, " valid"}, 32'(sum_valid), 32'd1);
    check({name, " sum"}, 32'(sum_out), 32'(exp));
    check({name, " hold sel"}, 32'(select_lines), 32'd0);
    check({name, " hold busy"}, 32'(busy), 32'd1);
    $display("sum %s: sum_out=%0h expected=%0h", name, sum_out, exp);
  endtask

  // Handshake edge with start low: back to IDLE, result retained.
  task automatic finish_idle(input logic [AW-1:0] exp, input string name);
    start = 1'b0;
    sum_ready = 1'b1;
    tick();
    check({name, " idle busy"}, 32'(busy), 32'd0);
    check({name, " idle valid"}, 32'(sum_valid), 32'd0);
    check({name, " idle sel"}, 32'(select_lines), 32'd0);
    check({name, " retained sum"}, 32'(sum_out), 32'(exp));
  endtask

  initial begin
    logic [AW-1:0] e;
    bit found;

    rst = 1'b1;
    start = 1'b0;
    sum_ready = 1'b0;
    load_const('0);
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset sel", 32'(select_lines), 32'd0);
    check("reset valid", 32'(sum_valid), 32'd0);
    check("reset sum", 32'(sum_out), 32'd0);

    // All ones, start on the very first edge after reset release.
    rst = 1'b0;
    load_const(OW'(1));
    sum_ready = 1'b1;
    start = 1'b1;
    run_sum(AW'(8), 1'b0, "ones");
    finish_idle(AW'(8), "ones");

    // Most negative products: -2^23 with no wrap.
    load_const(OW'(21'h100000));
    start = 1'b1;
    e = model_sum();
    check("negmax model", 32'(e), 32'h800000);
    run_sum(e, 1'b0, "negmax");
    finish_idle(e, "negmax");

    // Products 1..8 held 5 cycles with an ignored start pulse in HOLD.
    for (int i = 0; i < 8; i++) prod[i] = OW'(i + 1);
    sum_ready = 1'b0;
    start = 1'b1;
    run_sum(AW'(36), 1'b0, "hold");
    for (int d = 0; d < 5; d++) begin
      start = (d == 2);
      tick();
      check("hold valid", 32'(sum_valid), 32'd1);
      check("hold sum", 32'(sum_out), 32'd36);
      check("hold sel", 32'(select_lines), 32'd0);
      check("hold busy", 32'(busy), 32'd1);
    end
    finish_idle(AW'(36), "hold");

    // Back-to-back: handshake and start in the same cycle.
    sum_ready = 1'b1;
    load_random();
    e = model_sum();
    start = 1'b1;
    run_sum(e, 1'b0, "b2b first");
    load_random();
    e = model_sum();
    start = 1'b1;
    run_sum(e, 1'b0, "b2b second");
    finish_idle(e, "b2b second");

    // start held high continuously: one result per window, taps in order.
    sum_ready = 1'b1;
    start = 1'b1;
    for (int w = 0; w < 3; w++) begin
      load_random();
      e = model_sum();
      run_sum(e, 1'b1, "held start");
    end
    finish_idle(e, "held start");

    // Reset mid-ACCUM at tap 4, then a clean full sum.
    load_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (select_lines == 3'd4) found = 1'b1;
      else tick();
    end
    check("reach sel 4", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("mid-accum rst sel", 32'(select_lines), 32'd0);
    check("mid-accum rst valid", 32'(sum_valid), 32'd0);
    check("mid-accum rst busy", 32'(busy), 32'd0);
    check("mid-accum rst sum", 32'(sum_out), 32'd0);
    tick();
    rst = 1'b0;
    load_random();
    e = model_sum();
    start = 1'b1;
    run_sum(e, 1'b0, "after rst");
    finish_idle(e, "after rst");

    // Reset during HOLD discards the pending result.
    load_random();
    e = model_sum();
    sum_ready = 1'b0;
    start = 1'b1;
    run_sum(e, 1'b0, "rst hold");
    rst = 1'b1;
    #1;
    check("mid-hold rst valid", 32'(sum_valid), 32'd0);
    check("mid-hold rst sum", 32'(sum_out), 32'd0);
    check("mid-hold rst busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;

    // Random sums with random hold lengths.
    for (int n = 0; n < 4; n++) begin
      load_random();
      e = model_sum();
      sum_ready = 1'b0;
      start = 1'b1;
      run_sum(e, 1'b0, "random");
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        tick();
        check("random hold valid", 32'(sum_valid), 32'd1);
        check("random hold sum", 32'(sum_out), 32'(e));
      end
      finish_idle(e, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tap_accumulator
